// File: rtl/frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_scheduler_if
// Description : Frame-control and step handshake bundle between the VGA
//               timing / update engines and the frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_scheduler_if #(
    parameter int NUM_STEPS = 4
);
    logic                 animate;
    logic                 screenend;
    logic                 pause;
    logic [NUM_STEPS-1:0] step_en;
    logic [NUM_STEPS-1:0] step_done;
    logic [NUM_STEPS-1:0] step_req;
    logic                 busy;
    logic                 frame_done;
    logic [7:0]           frame_count;
    logic                 overrun;
    logic                 timeout;

    // Environment side: VGA timing and update engines
    modport master (
        output animate, screenend, pause, step_en, step_done,
        input  step_req, busy, frame_done, frame_count, overrun, timeout
    );

    // Scheduler side
    modport slave (
        input  animate, screenend, pause, step_en, step_done,
        output step_req, busy, frame_done, frame_count, overrun, timeout
    );
endinterface
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_scheduler
// Description : Sequences the per-frame update steps between animate and
//               screenend, with per-step timeout and overrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_scheduler #(
    parameter int NUM_STEPS    = 4,
    parameter int STEP_TIMEOUT = 1023
) (
    input  wire              clk,
    input  wire              reset,
    frame_scheduler_if.slave bus
);

    localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int TMR_W = $clog2(STEP_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [NUM_STEPS-1:0] step_req_q, step_req_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [7:0]           frame_count_q, frame_count_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            step_req_q    <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'd0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            step_req_q    <= step_req_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        overrun_d     = overrun_q;
        timeout_d     = timeout_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                if (bus.animate && !bus.pause) begin
                    state_d = CHECK;
                    idx_d   = '0;
                end
            end
            CHECK: begin
                if (bus.step_en[idx_q]) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RUN: begin
                // A done on the final timer cycle still counts as completion
                if (bus.step_done[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        state_d = CHECK;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The screen deadline overrides completion and timeout alike
        if (state_q != IDLE && bus.screenend) begin
            state_d   = IDLE;
            overrun_d = 1'b1;
            timeout_d = timeout_q;
        end

        if (state_d == IDLE) begin
            idx_d = '0;
        end
        if (state_d == FINISH) begin
            frame_count_d = frame_count_q + 8'd1;
        end

        // Outputs are registered from the next state so they align with it
        step_req_d   = (state_d == RUN) ? (NUM_STEPS'(1) << idx_d) : '0;
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == FINISH);
    end

    assign bus.step_req    = step_req_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_scheduler
// Description : Self-checking bench for frame_scheduler; per-frame timelines
//               are derived from the step plan and compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

    localparam int NS   = 4;
    localparam int TO   = 8;
    localparam int MAXC = 80;

    logic clk = 1'b0;
    logic reset;

    frame_scheduler_if #(.NUM_STEPS(NS)) bus ();

    frame_scheduler #(
        .NUM_STEPS    (NS),
        .STEP_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state carried between frames
    int m_cnt;
    bit m_ov;
    bit m_to;

    // Plan for the next frame
    logic [NS-1:0] p_en;
    int            p_d [NS];
    int            p_s;
    bit            p_pause;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: actual=%0h expected=%0h", tag, $time, act, exp);
        end
    endtask

    task automatic check_all(input string pfx, input logic [NS-1:0] req, input bit busy,
                             input bit fd, input int cnt, input bit ov, input bit to);
        check({pfx, "_req"},   32'(bus.step_req),    32'(req));
        check({pfx, "_busy"},  32'(bus.busy),        32'(busy));
        check({pfx, "_fdone"}, 32'(bus.frame_done),  32'(fd));
        check({pfx, "_count"}, 32'(bus.frame_count), 32'(cnt));
        check({pfx, "_ovr"},   32'(bus.overrun),     32'(ov));
        check({pfx, "_tmo"},   32'(bus.timeout),     32'(to));
    endtask

    task automatic drive_idle();
        bus.animate   = 1'b0;
        bus.screenend = 1'b0;
        bus.pause     = 1'b0;
        bus.step_en   = '0;
        bus.step_done = '0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.animate   = 1'b1;
        bus.screenend = 1'b1;
        bus.pause     = 1'b0;
        bus.step_en   = '1;
        bus.step_done = '1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", '0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive_idle();
        reset = 1'b0;
        m_cnt = 0;
        m_ov  = 1'b0;
        m_to  = 1'b0;
    endtask

    task automatic set_plan(input logic [NS-1:0] en, input int d0, input int d1,
                            input int d2, input int d3, input int s);
        p_en    = en;
        p_d[0]  = d0;
        p_d[1]  = d1;
        p_d[2]  = d2;
        p_d[3]  = d3;
        p_s     = s;
        p_pause = 1'b0;
    endtask

    task automatic random_plan(input bit allow_abort);
        p_en    = NS'($urandom());
        p_pause = allow_abort && ($urandom_range(0, 9) == 0);
        for (int i = 0; i < NS; i++) begin
            if (allow_abort && $urandom_range(0, 11) == 0)
                p_d[i] = TO + 1 + int'($urandom_range(0, 3));
            else
                p_d[i] = int'($urandom_range(1, TO));
        end
        p_s = (allow_abort && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
    endtask

    // Builds the expected per-cycle picture of one frame from the plan, then
    // drives stimulus and compares every cycle. Cycle 0 carries the animate pulse.
    task automatic run_frame();
        logic [NS-1:0] e_req  [MAXC];
        logic [NS-1:0] e_done [MAXC];
        bit            e_busy [MAXC];
        bit            e_fd   [MAXC];
        int  t, tt, fin, endb, last, exp_cnt;
        bit  ab, scr, inc, to_new;

        for (int k = 0; k < MAXC; k++) begin
            e_req[k] = '0; e_done[k] = '0; e_busy[k] = 1'b0; e_fd[k] = 1'b0;
        end

        if (p_pause) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                check_all("pause", '0, 1'b0, 1'b0, m_cnt, m_ov, m_to);
                bus.animate   = (k == 0);
                bus.pause     = 1'b1;
                bus.step_en   = p_en;
                bus.screenend = ($urandom_range(0, 3) == 0);
                bus.step_done = NS'($urandom());
            end
            drive_idle();
            return;
        end

        // t is the cycle in which the scheduler looks at the current step
        t  = 1;
        tt = 0;
        ab = 1'b0;
        for (int i = 0; i < NS && !ab; i++) begin
            if (p_en[i]) begin
                if (p_d[i] <= TO) begin
                    for (int c = t + 1; c <= t + p_d[i]; c++) e_req[c] = NS'(1) << i;
                    e_done[t + p_d[i]] = NS'(1) << i;
                    t = t + p_d[i] + 1;
                end else begin
                    for (int c = t + 1; c <= t + TO; c++) e_req[c] = NS'(1) << i;
                    tt = t + TO;
                    ab = 1'b1;
                end
            end else begin
                t = t + 1;
            end
        end
        fin  = ab ? -1 : t;
        endb = ab ? tt : t;
        scr  = (p_s >= 1) && (p_s <= endb);
        if (scr) endb = p_s;
        for (int k = 1; k <= endb; k++) e_busy[k] = 1'b1;
        for (int k = endb + 1; k < MAXC; k++) e_req[k] = '0;
        inc    = (fin > 0) && (fin <= endb);
        if (inc) e_fd[fin] = 1'b1;
        to_new = ab && !scr;
        last   = endb + 2;

        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            exp_cnt = (m_cnt + ((inc && k >= fin) ? 1 : 0)) % 256;
            check_all("frame", e_req[k], e_busy[k], e_fd[k], exp_cnt,
                      m_ov | (scr && k > p_s), m_to | (to_new && k > tt));
            bus.animate   = (k == 0) ? 1'b1 : (e_busy[k] && $urandom_range(0, 3) == 0);
            bus.pause     = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.screenend = (scr && k == p_s) || (!e_busy[k] && $urandom_range(0, 5) == 0);
            bus.step_en   = p_en;
            bus.step_done = e_done[k] | (NS'($urandom()) & ~e_req[k]);
        end
        drive_idle();

        m_cnt = (m_cnt + (inc ? 1 : 0)) % 256;
        m_ov  = m_ov | scr;
        m_to  = m_to | to_new;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        do_reset();

        // Nominal: all steps enabled, done three cycles into each request
        set_plan(4'b1111, 3, 3, 3, 3, -1);
        run_frame();
        check("nominal_count", 32'(bus.frame_count), 32'd1);

        // Masked steps, with a done on the very last permitted cycle
        set_plan(4'b0101, 2, 1, TO, 1, -1);
        run_frame();

        // Overrun while step 1 waits, then a normal frame must still start
        set_plan(4'b1111, 2, 100, 2, 2, 7);
        run_frame();
        check("overrun_flag", 32'(bus.overrun), 32'd1);
        set_plan(4'b1111, 1, 2, 3, 4, -1);
        run_frame();

        // Step 0 never completes
        set_plan(4'b0001, 100, 1, 1, 1, -1);
        run_frame();
        check("timeout_flag", 32'(bus.timeout), 32'd1);

        p_pause = 1'b1;
        run_frame();

        for (int n = 0; n < 150; n++) begin
            random_plan(1'b1);
            run_frame();
        end

        // Reset while step 2 is requested, then a stray done for step 2
        drive_idle();
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            bus.animate   = (k == 0);
            bus.step_en   = 4'b1111;
            bus.step_done = (k == 4) ? 4'b0001 : (k == 8) ? 4'b0010 : 4'b0000;
        end
        check("midrun_req", 32'(bus.step_req), 32'h4);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all("midrun_rst", '0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        reset         = 1'b0;
        bus.step_done = 4'b0100;
        m_cnt = 0;
        m_ov  = 1'b0;
        m_to  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.step_done = '0;
            check_all("post_rst", '0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        end

        // 256 completed frames bring the counter back to zero
        for (int n = 0; n < 256; n++) begin
            random_plan(1'b0);
            run_frame();
        end
        check("wrap_count", 32'(bus.frame_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
